// File: rtl/regmap_ctrl_pkg.sv
// Shared types for the register-map write scheduler: controller states and
// the retire queue entry layout.
package regmap_ctrl_pkg;

    localparam int RM_DATA_WIDTH     = 32;
    localparam int RM_REG_ADDR_WIDTH = 5;

    localparam logic [1:0] ST_RUN   = 2'd0;
    localparam logic [1:0] ST_DRAIN = 2'd1;
    localparam logic [1:0] ST_FLUSH = 2'd2;

    typedef enum logic [1:0] {
        RUN   = ST_RUN,
        DRAIN = ST_DRAIN,
        FLUSH = ST_FLUSH
    } ctrl_state_e;

    typedef struct packed {
        logic [RM_REG_ADDR_WIDTH-1:0] rdest;
        logic [RM_DATA_WIDTH-1:0]     data;
    } rq_entry_t;

endpackage

// File: rtl/regmap_retire_queue.sv
// In-order retire queue with per-entry valid bits and an rdest lookup used
// by the controller to detect a queued write to a register being renamed.
module regmap_retire_queue
    import regmap_ctrl_pkg::*;
#(
    parameter int RQ_DEPTH = 4,
    localparam int PTR_WIDTH = $clog2(RQ_DEPTH),
    localparam int CNT_WIDTH = PTR_WIDTH + 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push,
    input  rq_entry_t                    push_entry,
    input  logic                         pop,
    input  logic [RM_REG_ADDR_WIDTH-1:0] lookup_rdest,
    output logic                         lookup_hit,
    output rq_entry_t                    head,
    output logic                         empty,
    output logic [CNT_WIDTH-1:0]         count
);

    rq_entry_t              mem [RQ_DEPTH];
    logic [RQ_DEPTH-1:0]    valid;
    logic [PTR_WIDTH-1:0]   wr_ptr;
    logic [PTR_WIDTH-1:0]   rd_ptr;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            valid  <= '0;
        end else begin
            if (push) begin
                valid[wr_ptr] <= 1'b1;
                wr_ptr        <= wr_ptr + PTR_WIDTH'(1);
            end
            if (pop) begin
                valid[rd_ptr] <= 1'b0;
                rd_ptr        <= rd_ptr + PTR_WIDTH'(1);
            end
            count <= count + CNT_WIDTH'(push) - CNT_WIDTH'(pop);
        end
    end

    // Storage carries no reset; the valid bits alone qualify every entry.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= push_entry;
        end
    end

    always_comb begin
        lookup_hit = 1'b0;
        for (int i = 0; i < RQ_DEPTH; i++) begin
            if (valid[i] && (mem[i].rdest == lookup_rdest)) begin
                lookup_hit = 1'b1;
            end
        end
    end

    assign head  = mem[rd_ptr];
    assign empty = (count == '0);

endmodule

// File: rtl/regmap_update_ctrl.sv
// Sole writer of the register map: orders rename tag writes behind older
// committed-value writes and drains the retire queue before any map flush.
//
// state | meaning
// RUN   | accepting dispatch and retire, queue drains one entry per cycle
// DRAIN | flush pending, inputs blocked, emptying the retire queue
// FLUSH | queue empty, o_regmap_flush asserted for this single cycle
module regmap_update_ctrl
    import regmap_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH   = RM_DATA_WIDTH,
    parameter int REGMAP_DEPTH = 32,
    parameter int TAG_WIDTH    = 6,
    parameter int RQ_DEPTH     = 4,
    localparam int REG_ADDR_WIDTH = $clog2(REGMAP_DEPTH),
    localparam int CNT_WIDTH      = $clog2(RQ_DEPTH) + 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      i_flush_req,
    output logic                      o_flush_busy,
    input  logic                      i_disp_valid,
    output logic                      o_disp_ready,
    input  logic [REG_ADDR_WIDTH-1:0] i_disp_rdest,
    input  logic [TAG_WIDTH-1:0]      i_disp_tag,
    input  logic                      i_ret_valid,
    output logic                      o_ret_ready,
    input  logic [REG_ADDR_WIDTH-1:0] i_ret_rdest,
    input  logic [DATA_WIDTH-1:0]     i_ret_data,
    output logic                      o_tag_wr_en,
    output logic [REG_ADDR_WIDTH-1:0] o_tag_wr_rdest,
    output logic [TAG_WIDTH-1:0]      o_tag_wr_tag,
    output logic                      o_dest_wr_en,
    output logic [REG_ADDR_WIDTH-1:0] o_dest_wr_rdest,
    output logic [DATA_WIDTH-1:0]     o_dest_wr_data,
    output logic                      o_regmap_flush,
    output logic [CNT_WIDTH-1:0]      o_rq_count
);

    ctrl_state_e            state;
    rq_entry_t              ret_entry;
    rq_entry_t              q_head;
    logic                   q_empty;
    logic                   q_hit;
    logic [CNT_WIDTH-1:0]   q_count;
    logic                   ret_accept;
    logic                   q_push;
    logic                   q_pop;
    logic                   disp_accept;
    logic                   hazard;

    assign ret_entry.rdest = i_ret_rdest;
    assign ret_entry.data  = i_ret_data;

    assign ret_accept  = i_ret_valid && o_ret_ready;
    assign q_push      = ret_accept && (i_ret_rdest != '0);
    assign q_pop       = !q_empty;

    // A retire entering an empty queue reaches the map alongside the tag
    // write, which the map resolves in the tag's favour, so no stall there.
    assign hazard = (i_disp_rdest != '0) &&
                    (q_hit || (ret_accept && !q_empty && (i_ret_rdest == i_disp_rdest)));

    assign o_ret_ready  = (state == RUN) && (q_count < CNT_WIDTH'(RQ_DEPTH));
    assign o_disp_ready = (state == RUN) && !i_flush_req && !hazard;
    assign disp_accept  = i_disp_valid && o_disp_ready;

    regmap_retire_queue #(
        .RQ_DEPTH (RQ_DEPTH)
    ) u_rq (
        .clk          (clk),
        .rst          (rst),
        .push         (q_push),
        .push_entry   (ret_entry),
        .pop          (q_pop),
        .lookup_rdest (i_disp_rdest),
        .lookup_hit   (q_hit),
        .head         (q_head),
        .empty        (q_empty),
        .count        (q_count)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= RUN;
        end else begin
            case (state)
                RUN:     if (i_flush_req) state <= DRAIN;
                DRAIN:   if (q_count <= CNT_WIDTH'(1)) state <= FLUSH;
                FLUSH:   state <= RUN;
                default: state <= RUN;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            o_tag_wr_en    <= 1'b0;
            o_tag_wr_rdest <= '0;
            o_tag_wr_tag   <= '0;
        end else begin
            o_tag_wr_en <= disp_accept && (i_disp_rdest != '0);
            if (disp_accept && (i_disp_rdest != '0)) begin
                o_tag_wr_rdest <= i_disp_rdest;
                o_tag_wr_tag   <= i_disp_tag;
            end
        end
    end

    assign o_dest_wr_en    = !q_empty;
    assign o_dest_wr_rdest = q_empty ? '0 : q_head.rdest;
    assign o_dest_wr_data  = q_empty ? '0 : q_head.data;

    assign o_regmap_flush = (state == FLUSH);
    assign o_flush_busy   = (state != RUN);
    assign o_rq_count     = q_count;

endmodule

// File: tb/tb_regmap_update_ctrl.sv
// Self-checking bench for regmap_update_ctrl: per-cycle vector table plus a
// scoreboard of expected map writes tagged with the cycle they must appear in.
module tb_regmap_update_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        i_flush_req = 1'b0;
    logic        o_flush_busy;
    logic        i_disp_valid = 1'b0;
    logic        o_disp_ready;
    logic [4:0]  i_disp_rdest = '0;
    logic [5:0]  i_disp_tag = '0;
    logic        i_ret_valid = 1'b0;
    logic        o_ret_ready;
    logic [4:0]  i_ret_rdest = '0;
    logic [31:0] i_ret_data = '0;
    logic        o_tag_wr_en;
    logic [4:0]  o_tag_wr_rdest;
    logic [5:0]  o_tag_wr_tag;
    logic        o_dest_wr_en;
    logic [4:0]  o_dest_wr_rdest;
    logic [31:0] o_dest_wr_data;
    logic        o_regmap_flush;
    logic [2:0]  o_rq_count;

    regmap_update_ctrl dut (
        .clk             (clk),
        .rst             (rst),
        .i_flush_req     (i_flush_req),
        .o_flush_busy    (o_flush_busy),
        .i_disp_valid    (i_disp_valid),
        .o_disp_ready    (o_disp_ready),
        .i_disp_rdest    (i_disp_rdest),
        .i_disp_tag      (i_disp_tag),
        .i_ret_valid     (i_ret_valid),
        .o_ret_ready     (o_ret_ready),
        .i_ret_rdest     (i_ret_rdest),
        .i_ret_data      (i_ret_data),
        .o_tag_wr_en     (o_tag_wr_en),
        .o_tag_wr_rdest  (o_tag_wr_rdest),
        .o_tag_wr_tag    (o_tag_wr_tag),
        .o_dest_wr_en    (o_dest_wr_en),
        .o_dest_wr_rdest (o_dest_wr_rdest),
        .o_dest_wr_data  (o_dest_wr_data),
        .o_regmap_flush  (o_regmap_flush),
        .o_rq_count      (o_rq_count)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        rv;
        logic [4:0]  rrd;
        logic [31:0] rd;
        logic        dv;
        logic [4:0]  drd;
        logic [5:0]  dtag;
        logic        fl;
        logic        e_rr;
        logic        e_dr;
        logic        e_busy;
        logic        e_fl;
        logic [2:0]  e_cnt;
    } vec_t;

    typedef struct { logic [4:0] rd; logic [31:0] data; int at; } dexp_t;
    typedef struct { logic [4:0] rd; logic [5:0]  tag;  int at; } texp_t;

    dexp_t exp_dest[$];
    texp_t exp_tag[$];
    dexp_t de;
    texp_t te;
    int    last_dest_at = -100;
    bit    mon_en = 1'b0;
    vec_t  tbl[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic vec_t mk(input logic rv, input logic [4:0] rrd, input logic [31:0] rd,
                                input logic dv, input logic [4:0] drd, input logic [5:0] dtag,
                                input logic fl, input logic e_rr, input logic e_dr,
                                input logic e_busy, input logic e_fl, input logic [2:0] e_cnt);
        vec_t v;
        v.rv = rv; v.rrd = rrd; v.rd = rd;
        v.dv = dv; v.drd = drd; v.dtag = dtag; v.fl = fl;
        v.e_rr = e_rr; v.e_dr = e_dr; v.e_busy = e_busy; v.e_fl = e_fl; v.e_cnt = e_cnt;
        return v;
    endfunction

    function automatic vec_t idle(input logic e_rr, input logic e_dr, input logic e_busy,
                                  input logic e_fl, input logic [2:0] e_cnt);
        return mk(0, 0, 0, 0, 0, 0, 0, e_rr, e_dr, e_busy, e_fl, e_cnt);
    endfunction

    // One vector per cycle; expected writes are queued with their due cycle.
    task automatic apply(input vec_t v, input int idx);
        int at;
        @(posedge clk);
        #1;
        i_ret_valid  = v.rv;
        i_ret_rdest  = v.rrd;
        i_ret_data   = v.rd;
        i_disp_valid = v.dv;
        i_disp_rdest = v.drd;
        i_disp_tag   = v.dtag;
        i_flush_req  = v.fl;
        #3;
        chk($sformatf("row%0d_ret_ready", idx),    o_ret_ready,    v.e_rr);
        chk($sformatf("row%0d_disp_ready", idx),   o_disp_ready,   v.e_dr);
        chk($sformatf("row%0d_flush_busy", idx),   o_flush_busy,   v.e_busy);
        chk($sformatf("row%0d_regmap_flush", idx), o_regmap_flush, v.e_fl);
        chk($sformatf("row%0d_rq_count", idx),     o_rq_count,     v.e_cnt);
        if (v.e_rr && v.rv && (v.rrd != 5'd0)) begin
            at = (cyc + 1 > last_dest_at + 1) ? cyc + 1 : last_dest_at + 1;
            exp_dest.push_back('{v.rrd, v.rd, at});
            last_dest_at = at;
        end
        if (v.e_dr && v.dv && (v.drd != 5'd0)) begin
            exp_tag.push_back('{v.drd, v.dtag, cyc + 1});
        end
    endtask

    always @(negedge clk) begin
        if (mon_en && !rst) begin
            if (o_dest_wr_en) begin
                if (exp_dest.size() == 0) begin
                    chk("dest_wr_unexpected", o_dest_wr_en, 1'b0);
                end else begin
                    de = exp_dest.pop_front();
                    chk("dest_wr_rdest", o_dest_wr_rdest, de.rd);
                    chk("dest_wr_data", o_dest_wr_data, de.data);
                    chk("dest_wr_cycle", cyc, de.at);
                end
            end
            if (o_tag_wr_en) begin
                if (exp_tag.size() == 0) begin
                    chk("tag_wr_unexpected", o_tag_wr_en, 1'b0);
                end else begin
                    te = exp_tag.pop_front();
                    chk("tag_wr_rdest", o_tag_wr_rdest, te.rd);
                    chk("tag_wr_tag", o_tag_wr_tag, te.tag);
                    chk("tag_wr_cycle", cyc, te.at);
                end
            end
        end
    end

    initial begin
        // back-to-back retires r3..r7, with an unrelated dispatch r8 alongside
        tbl.push_back(mk(1, 3, 32'hA, 0, 0, 0,     0, 1, 1, 0, 0, 0));
        tbl.push_back(mk(1, 4, 32'hB, 1, 8, 6'h08, 0, 1, 1, 0, 0, 1));
        tbl.push_back(mk(1, 5, 32'hC, 0, 0, 0,     0, 1, 1, 0, 0, 1));
        tbl.push_back(mk(1, 6, 32'hD, 0, 0, 0,     0, 1, 1, 0, 0, 1));
        tbl.push_back(mk(1, 7, 32'hE, 0, 0, 0,     0, 1, 1, 0, 0, 1));
        tbl.push_back(idle(1, 1, 0, 0, 1));
        tbl.push_back(idle(1, 1, 0, 0, 0));
        // queued r5 blocks dispatch r5 until it has been written
        tbl.push_back(mk(1, 5, 32'h55, 0, 0, 0,     0, 1, 1, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0,      1, 5, 6'h12, 0, 1, 0, 0, 0, 1));
        tbl.push_back(mk(0, 0, 0,      1, 5, 6'h12, 0, 1, 1, 0, 0, 0));
        tbl.push_back(idle(1, 1, 0, 0, 0));
        // same-cycle retire r5 into a non-empty queue blocks dispatch r5
        tbl.push_back(mk(1, 3, 32'h33, 0, 0, 0,     0, 1, 1, 0, 0, 0));
        tbl.push_back(mk(1, 5, 32'h5A, 1, 5, 6'h21, 0, 1, 0, 0, 0, 1));
        tbl.push_back(mk(0, 0, 0,      1, 5, 6'h21, 0, 1, 0, 0, 0, 1));
        tbl.push_back(mk(0, 0, 0,      1, 5, 6'h21, 0, 1, 1, 0, 0, 0));
        tbl.push_back(idle(1, 1, 0, 0, 0));
        // retire r9 into an empty queue with dispatch r9 in the same cycle
        tbl.push_back(mk(1, 9, 32'h99, 1, 9, 6'h07, 0, 1, 1, 0, 0, 0));
        tbl.push_back(idle(1, 1, 0, 0, 1));
        // r0 traffic is accepted and dropped
        tbl.push_back(mk(1, 0, 32'hDEAD, 1, 0, 6'h3F, 0, 1, 1, 0, 0, 0));
        tbl.push_back(idle(1, 1, 0, 0, 0));
        // flush with a retire accepted in the request cycle, repeated requests merged
        tbl.push_back(mk(1, 10, 32'h100, 0, 0,  0,     0, 1, 1, 0, 0, 0));
        tbl.push_back(mk(1, 11, 32'h111, 1, 12, 6'h0C, 1, 1, 0, 0, 0, 1));
        tbl.push_back(mk(1, 13, 32'h13,  1, 12, 6'h0C, 1, 0, 0, 1, 0, 1));
        tbl.push_back(mk(0, 0,  0,       0, 0,  0,     1, 0, 0, 1, 1, 0));
        tbl.push_back(idle(1, 1, 0, 0, 0));
        tbl.push_back(idle(1, 1, 0, 0, 0));
        // flush with an empty queue: DRAIN, FLUSH, RUN
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0));
        tbl.push_back(idle(0, 0, 1, 0, 0));
        tbl.push_back(idle(0, 0, 1, 1, 0));
        tbl.push_back(idle(1, 1, 0, 0, 0));

        repeat (3) @(posedge clk);
        #1;
        chk("rst_rq_count",      o_rq_count,      3'd0);
        chk("rst_ret_ready",     o_ret_ready,     1'b1);
        chk("rst_disp_ready",    o_disp_ready,    1'b1);
        chk("rst_flush_busy",    o_flush_busy,    1'b0);
        chk("rst_regmap_flush",  o_regmap_flush,  1'b0);
        chk("rst_dest_wr_en",    o_dest_wr_en,    1'b0);
        chk("rst_dest_wr_rdest", o_dest_wr_rdest, 5'd0);
        chk("rst_dest_wr_data",  o_dest_wr_data,  32'd0);
        chk("rst_tag_wr_en",     o_tag_wr_en,     1'b0);
        chk("rst_tag_wr_rdest",  o_tag_wr_rdest,  5'd0);
        chk("rst_tag_wr_tag",    o_tag_wr_tag,    6'd0);
        rst    = 1'b0;
        mon_en = 1'b1;

        for (int i = 0; i < tbl.size(); i++) begin
            apply(tbl[i], i);
        end

        // reset while draining: entry discarded, no flush, back in RUN
        apply(mk(1, 14, 32'h140, 0, 0, 0, 0, 1, 1, 0, 0, 0), 100);
        apply(mk(1, 15, 32'h150, 0, 0, 0, 1, 1, 0, 0, 0, 1), 101);
        @(posedge clk);
        #1;
        i_ret_valid = 1'b0;
        i_flush_req = 1'b0;
        #3;
        chk("drain_busy", o_flush_busy, 1'b1);
        chk("drain_count", o_rq_count, 3'd1);
        rst = 1'b1;
        exp_dest.delete();
        last_dest_at = -100;
        @(posedge clk);
        #1;
        rst = 1'b0;
        #3;
        chk("mid_rst_count", o_rq_count, 3'd0);
        chk("mid_rst_busy", o_flush_busy, 1'b0);
        chk("mid_rst_flush", o_regmap_flush, 1'b0);
        chk("mid_rst_ret_ready", o_ret_ready, 1'b1);
        chk("mid_rst_dest_wr_en", o_dest_wr_en, 1'b0);
        @(posedge clk);
        #4;
        chk("post_rst_flush", o_regmap_flush, 1'b0);
        chk("post_rst_busy", o_flush_busy, 1'b0);

        repeat (3) @(posedge clk);
        #4;
        chk("dest_writes_outstanding", exp_dest.size(), 0);
        chk("tag_writes_outstanding", exp_tag.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
